// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor for the 5-stage RV32 pipeline.
// A direct-mapped BTB with 2-bit saturating counters is looked up at Fetch.
// The prediction rides the F/D and D/E registers and is checked against the
// Execute-stage resolution, which raises a redirect and trains the table.
module branch_predict_unit #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        PCSrcE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // BTB storage: valid bits and counters are reset, tags and targets are not.
  logic [ENTRIES-1:0]       r_valid;
  logic [ENTRIES-1:0][1:0]  r_ctr;
  logic [TAG_BITS-1:0]      r_tag    [ENTRIES];
  logic [31:0]              r_target [ENTRIES];

  // Pipeline copies of the prediction.
  logic        r_pred_taken_d;
  logic [31:0] r_pred_target_d;
  logic        r_pred_taken_e;
  logic [31:0] r_pred_target_e;

  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Fetch-side lookup signals.
  logic [INDEX_BITS-1:0] w_idx_f;
  logic [TAG_BITS-1:0]   w_tag_f;
  logic                  w_hit_f;
  logic                  w_unused_pcf_lsbs;

  // Execute-side resolve/update signals.
  logic [INDEX_BITS-1:0] w_idx_e;
  logic [TAG_BITS-1:0]   w_tag_e;
  logic                  w_hit_e;
  logic                  w_resolving;
  logic                  w_mispredict;
  logic [1:0]            w_ctr_e;
  logic [1:0]            w_ctr_next;

  assign w_idx_f           = PCF[INDEX_BITS+1:2];
  assign w_tag_f           = PCF[31:INDEX_BITS+2];
  assign w_unused_pcf_lsbs = ^PCF[1:0];
  assign w_hit_f           = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);

  assign PredTakenF  = w_hit_f & r_ctr[w_idx_f][1];
  assign PredTargetF = w_hit_f ? r_target[w_idx_f] : 32'd0;

  assign w_idx_e     = PCE[INDEX_BITS+1:2];
  assign w_tag_e     = PCE[31:INDEX_BITS+2];
  assign w_hit_e     = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
  assign w_ctr_e     = r_ctr[w_idx_e];
  assign w_resolving = BranchE | JumpE;

  assign w_mispredict = w_resolving &
                        ((r_pred_taken_e != PCSrcE) |
                         (PCSrcE & (r_pred_target_e != PCTargetE)));

  // The redirect is suppressed while reset is held so no stale request escapes.
  assign MispredictE     = w_mispredict & ~reset;
  assign RedirectPCE     = PCSrcE ? PCTargetE : (PCE + 32'd4);
  assign BranchCount     = r_branch_count;
  assign MispredictCount = r_mispredict_count;

  // Saturating counter step for the entry being trained.
  always_comb begin
    // NOTE: a default on every always_comb output keeps synthesis from inferring latches.
    w_ctr_next = w_ctr_e;
    if (PCSrcE) begin
      if (w_ctr_e != 2'b11) w_ctr_next = w_ctr_e + 2'b01;
    end else begin
      if (w_ctr_e != 2'b00) w_ctr_next = w_ctr_e - 2'b01;
    end
  end

  // Valid bits and counters: allocate on a taken miss, train on a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      r_valid <= '0;
      r_ctr   <= '0;
    end else if (w_resolving) begin
      if (w_hit_e) begin
        r_ctr[w_idx_e] <= w_ctr_next;
      end else if (PCSrcE) begin
        r_valid[w_idx_e] <= 1'b1;
        r_ctr[w_idx_e]   <= 2'b10;
      end
    end
  end

  // Tag and target payload, written on every taken resolve (hit or allocate).
  always_ff @(posedge clk) begin
    // NOTE: the payload arrays have no reset; the cleared valid bit masks them, which keeps them plain RAM.
    if (w_resolving && PCSrcE) begin
      r_tag[w_idx_e]    <= w_tag_e;
      r_target[w_idx_e] <= PCTargetE;
    end
  end

  // F/D prediction register: flush beats stall, stall beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= 32'd0;
    end else if (FlushD) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= 32'd0;
    end else if (!StallD) begin
      r_pred_taken_d  <= PredTakenF;
      r_pred_target_d <= PredTargetF;
    end
  end

  // D/E prediction register: only a flush interrupts the load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_taken_e  <= 1'b0;
      r_pred_target_e <= 32'd0;
    end else if (FlushE) begin
      r_pred_taken_e  <= 1'b0;
      r_pred_target_e <= 32'd0;
    end else begin
      r_pred_taken_e  <= r_pred_taken_d;
      r_pred_target_e <= r_pred_target_d;
    end
  end

  // Statistics: resolved control transfers and mispredicts, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else if (w_resolving) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a directed vector table for the
// trained-branch scenarios, hand sequences for reset, and a random phase
// compared against a behavioural model of the predictor.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        StallD, FlushD, FlushE;
  logic        BranchE, JumpE, PCSrcE;
  logic [31:0] PCE, PCTargetE;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCount, MispredictCount;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predict_unit dut (
    .clk             (clk),
    .reset           (reset),
    .PCF             (PCF),
    .StallD          (StallD),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .BranchE         (BranchE),
    .JumpE           (JumpE),
    .PCSrcE          (PCSrcE),
    .PCE             (PCE),
    .PCTargetE       (PCTargetE),
    .PredTakenF      (PredTakenF),
    .PredTargetF     (PredTargetF),
    .MispredictE     (MispredictE),
    .RedirectPCE     (RedirectPCE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic        sd, fd, fe, br, jp, src;
    logic [31:0] pce, tgt;
    logic        e_ptf;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_red, e_bc, e_mc;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ptf, input logic [31:0] e_ptgt,
                           input logic e_mis, input logic [31:0] e_red,
                           input logic [31:0] e_bc, input logic [31:0] e_mc);
    check({tag, " PredTakenF"},      {31'd0, PredTakenF},  {31'd0, e_ptf});
    check({tag, " PredTargetF"},     PredTargetF,          e_ptgt);
    check({tag, " MispredictE"},     {31'd0, MispredictE}, {31'd0, e_mis});
    check({tag, " RedirectPCE"},     RedirectPCE,          e_red);
    check({tag, " BranchCount"},     BranchCount,          e_bc);
    check({tag, " MispredictCount"}, MispredictCount,      e_mc);
  endtask

  task automatic idle_inputs();
    PCF = 32'h3004; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    BranchE = 1'b0; JumpE = 1'b0; PCSrcE = 1'b0; PCE = 32'd0; PCTargetE = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic        m_fd_t, m_de_t;
  logic [31:0] m_fd_tgt, m_de_tgt, m_bc, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd64);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> 8;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
      m_tag[i]   = 32'd0;
      m_tgt[i]   = 32'd0;
    end
    m_fd_t = 1'b0; m_fd_tgt = 32'd0; m_de_t = 1'b0; m_de_tgt = 32'd0;
    m_bc = 32'd0; m_mc = 32'd0;
  endtask

  logic [31:0] pc_pool  [6] = '{32'h100, 32'h200, 32'h104, 32'h300, 32'h1100, 32'h3004};
  logic [31:0] tgt_pool [4] = '{32'h40, 32'h44, 32'h80, 32'h104};

  initial begin
    // Directed sequence: cold miss, training, hysteresis, aliasing, stall/flush.
    vecs[0]  = '{32'h3004,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h100,32'h80, 1'b0,32'h0, 1'b1,32'h80, 32'd0, 32'd0};
    vecs[1]  = '{32'h100, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b1,32'h80,1'b0,32'h4,  32'd1, 32'd1};
    vecs[2]  = '{32'h100, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b1,32'h80,1'b0,32'h4,  32'd1, 32'd1};
    vecs[3]  = '{32'h100, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h100,32'h80, 1'b1,32'h80,1'b0,32'h80, 32'd1, 32'd1};
    vecs[4]  = '{32'h100, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h100,32'h80, 1'b1,32'h80,1'b0,32'h80, 32'd2, 32'd1};
    vecs[5]  = '{32'h100, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h100,32'h80, 1'b1,32'h80,1'b1,32'h104,32'd3, 32'd1};
    vecs[6]  = '{32'h100, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h100,32'h80, 1'b1,32'h80,1'b1,32'h104,32'd4, 32'd2};
    vecs[7]  = '{32'h100, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h80,1'b0,32'h4,  32'd5, 32'd3};
    vecs[8]  = '{32'h3004,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h200,32'h40, 1'b0,32'h0, 1'b1,32'h40, 32'd5, 32'd3};
    vecs[9]  = '{32'h100, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h0, 1'b0,32'h4,  32'd6, 32'd4};
    vecs[10] = '{32'h200, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b1,32'h40,1'b0,32'h4,  32'd6, 32'd4};
    vecs[11] = '{32'h3004,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h0, 1'b0,32'h4,  32'd6, 32'd4};
    vecs[12] = '{32'h200, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h200,32'h44, 1'b1,32'h40,1'b1,32'h44, 32'd6, 32'd4};
    vecs[13] = '{32'h200, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b1,32'h44,1'b0,32'h4,  32'd7, 32'd5};
    vecs[14] = '{32'h3004,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h0, 1'b0,32'h4,  32'd7, 32'd5};
    vecs[15] = '{32'h3004,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h0, 1'b0,32'h4,  32'd7, 32'd5};
    vecs[16] = '{32'h3004,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h0, 1'b0,32'h4,  32'd7, 32'd5};
    vecs[17] = '{32'h3004,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h200,32'h44, 1'b0,32'h0, 1'b0,32'h44, 32'd7, 32'd5};
    vecs[18] = '{32'h200, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b1,32'h44,1'b0,32'h4,  32'd8, 32'd5};
    vecs[19] = '{32'h3004,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h0, 1'b0,32'h4,  32'd8, 32'd5};
    vecs[20] = '{32'h3004,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h0, 1'b0,32'h4,  32'd8, 32'd5};
    vecs[21] = '{32'h3004,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h200,32'h44, 1'b0,32'h0, 1'b1,32'h44, 32'd8, 32'd5};
    vecs[22] = '{32'h200, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b1,32'h44,1'b0,32'h4,  32'd9, 32'd6};
    vecs[23] = '{32'h3004,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h0, 1'b0,32'h4,  32'd9, 32'd6};
    vecs[24] = '{32'h3004,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h200,32'h44, 1'b0,32'h0, 1'b1,32'h204,32'd9, 32'd6};
    vecs[25] = '{32'h3004,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h200,32'h44, 1'b0,32'h0, 1'b0,32'h204,32'd10,32'd7};
    vecs[26] = '{32'h200, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,  1'b0,32'h44,1'b0,32'h4,  32'd11,32'd7};

    // Reset state.
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'd0, 1'b0, 32'd4, 32'd0, 32'd0);
    reset = 1'b0;
    next_cycle();

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      PCF = vecs[i].pcf; StallD = vecs[i].sd; FlushD = vecs[i].fd; FlushE = vecs[i].fe;
      BranchE = vecs[i].br; JumpE = vecs[i].jp; PCSrcE = vecs[i].src;
      PCE = vecs[i].pce; PCTargetE = vecs[i].tgt;
      #3;
      check_all($sformatf("row%0d", i), vecs[i].e_ptf, vecs[i].e_ptgt, vecs[i].e_mis,
                vecs[i].e_red, vecs[i].e_bc, vecs[i].e_mc);
      next_cycle();
    end

    // Reset during a resolving cycle: taken miss at 0x108 must not allocate.
    idle_inputs();
    PCF = 32'h200; BranchE = 1'b1; PCSrcE = 1'b1; PCE = 32'h108; PCTargetE = 32'h90;
    #1;
    check("pre-reset BranchCount",     BranchCount,     32'd11);
    check("pre-reset MispredictCount", MispredictCount, 32'd7);
    reset = 1'b1;
    #1;
    check("midreset PredTakenF",      {31'd0, PredTakenF},  32'd0);
    check("midreset PredTargetF",     PredTargetF,          32'd0);
    check("midreset MispredictE",     {31'd0, MispredictE}, 32'd0);
    check("midreset BranchCount",     BranchCount,          32'd0);
    check("midreset MispredictCount", MispredictCount,      32'd0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    PCF = 32'h108;
    #2;
    check("postreset 0x108 PredTakenF",  {31'd0, PredTakenF}, 32'd0);
    check("postreset 0x108 PredTargetF", PredTargetF,         32'd0);
    check("postreset BranchCount",       BranchCount,         32'd0);
    PCF = 32'h100;
    #1;
    check("postreset 0x100 PredTakenF",  {31'd0, PredTakenF}, 32'd0);
    check("postreset 0x100 PredTargetF", PredTargetF,         32'd0);
    next_cycle();

    // Random phase against the behavioural model.
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        hit_f, hit_e, resolving, e_ptf, e_mis;
      logic [31:0] e_ptgt, pred_next, actual_next;
      int          fi, ei;
      PCF       = pc_pool[$urandom_range(0, 5)];
      StallD    = ($urandom_range(0, 4) == 0);
      FlushD    = ($urandom_range(0, 7) == 0);
      FlushE    = ($urandom_range(0, 7) == 0);
      BranchE   = ($urandom_range(0, 2) == 0);
      JumpE     = ($urandom_range(0, 5) == 0);
      PCSrcE    = ($urandom_range(0, 2) != 0);
      PCE       = pc_pool[$urandom_range(0, 5)];
      PCTargetE = tgt_pool[$urandom_range(0, 3)];
      #3;
      fi        = idx_of(PCF);
      hit_f     = m_valid[fi] && (m_tag[fi] == tag_of(PCF));
      e_ptf     = hit_f && (m_ctr[fi] >= 2);
      e_ptgt    = hit_f ? m_tgt[fi] : 32'd0;
      resolving = BranchE || JumpE;
      pred_next   = m_de_t ? m_de_tgt : PCE + 32'd4;
      actual_next = PCSrcE ? PCTargetE : PCE + 32'd4;
      e_mis     = resolving && ((m_de_t != PCSrcE) || (pred_next != actual_next));
      check_all($sformatf("rand%0d", cyc), e_ptf, e_ptgt, e_mis, actual_next, m_bc, m_mc);

      // Advance the model across the clock edge.
      if (FlushE) begin
        m_de_t = 1'b0; m_de_tgt = 32'd0;
      end else begin
        m_de_t = m_fd_t; m_de_tgt = m_fd_tgt;
      end
      if (FlushD) begin
        m_fd_t = 1'b0; m_fd_tgt = 32'd0;
      end else if (!StallD) begin
        m_fd_t = e_ptf; m_fd_tgt = e_ptgt;
      end
      if (resolving) begin
        m_bc = m_bc + 32'd1;
        if (e_mis) m_mc = m_mc + 32'd1;
        ei    = idx_of(PCE);
        hit_e = m_valid[ei] && (m_tag[ei] == tag_of(PCE));
        if (hit_e) begin
          if (PCSrcE) begin
            m_ctr[ei] = (m_ctr[ei] + 1 > 3) ? 3 : m_ctr[ei] + 1;
            m_tgt[ei] = PCTargetE;
          end else begin
            m_ctr[ei] = (m_ctr[ei] - 1 < 0) ? 0 : m_ctr[ei] - 1;
          end
        end else if (PCSrcE) begin
          m_valid[ei] = 1'b1;
          m_tag[ei]   = tag_of(PCE);
          m_tgt[ei]   = PCTargetE;
          m_ctr[ei]   = 2;
        end
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
